// File: rtl/nav_pkg.sv
// Shared encodings for the line-following car's maze navigation controller:
// FSM states, motor commands, tracker patterns and junction priority ranks.
package nav_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ARM      = 4'd1,
        ST_COUNT    = 4'd2,
        ST_FOLLOW   = 4'd3,
        ST_JUNCTION = 4'd4,
        ST_CROSS    = 4'd5,
        ST_TURN     = 4'd6,
        ST_UTURN    = 4'd7,
        ST_DONE     = 4'd8,
        ST_ERROR    = 4'd9
    } nav_state_e;

    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_FWD   = 3'd1;
    localparam logic [2:0] CMD_LEFT  = 3'd2;
    localparam logic [2:0] CMD_RIGHT = 3'd3;
    localparam logic [2:0] CMD_SPIN  = 3'd4;

    localparam logic [2:0] DET_NONE = 3'b000;
    localparam logic [2:0] DET_MID  = 3'b010;
    localparam logic [2:0] DET_GOAL = 3'b101;
    localparam logic [2:0] DET_ALL  = 3'b111;

    localparam logic [1:0] RANK_FIRST = 2'd0;
    localparam logic [1:0] RANK_MID   = 2'd1;
    localparam logic [1:0] RANK_LAST  = 2'd2;

    // Rank 1 is always straight; ranks 0 and 2 swap sides with the hand rule.
    function automatic logic [2:0] rank_cmd(input logic right_hand, input logic [1:0] rank);
        logic [2:0] cmd;
        case (rank)
            RANK_FIRST: cmd = right_hand ? CMD_RIGHT : CMD_LEFT;
            RANK_MID:   cmd = CMD_FWD;
            RANK_LAST:  cmd = right_hand ? CMD_LEFT : CMD_RIGHT;
            default:    cmd = CMD_STOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/decision_stack.sv
// LIFO of 2-bit junction ranks; push together with pop overwrites the top entry.
module decision_stack #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [1:0]                 push_data,
    output logic                       full,
    output logic                       empty,
    output logic [1:0]                 top,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [1:0]    mem_r [DEPTH];
    logic [CW-1:0] ptr_r;
    logic [IW-1:0] top_idx_s;
    logic [IW-1:0] wr_idx_s;

    assign top_idx_s = IW'(ptr_r - CW'(1));
    assign wr_idx_s  = IW'(ptr_r);
    assign full      = (ptr_r == CW'(DEPTH));
    assign empty     = (ptr_r == {CW{1'b0}});
    assign top       = empty ? 2'd0 : mem_r[top_idx_s];
    assign count     = ptr_r;

    // Stack pointer and storage update; illegal push/pop are ignored here.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 2'd0;
            end
        end else if (clr) begin
            ptr_r <= {CW{1'b0}};
        end else if (push && pop) begin
            if (!empty) begin
                mem_r[top_idx_s] <= push_data;
            end
        end else if (push) begin
            if (!full) begin
                mem_r[wr_idx_s] <= push_data;
                ptr_r           <= ptr_r + CW'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                ptr_r <= ptr_r - CW'(1);
            end
        end
    end

endmodule

// File: rtl/maze_navigator.sv
// Maze navigation controller: debounced tracker input, start countdown,
// hand-rule junction choice with a backtracking decision stack.
module maze_navigator
    import nav_pkg::*;
#(
    parameter int STACK_DEPTH  = 16,
    parameter int DEBOUNCE     = 4,
    parameter int START_CYCLES = 100_000_000,
    parameter int TURN_TIMEOUT = 200_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             priority_mode,
    input  logic [2:0]                       detect,
    input  logic                             obstacle,
    output logic [2:0]                       motor_cmd,
    output logic [3:0]                       state_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             done,
    output logic                             error
);

    localparam int BW = $clog2(DEBOUNCE + 1);

    nav_state_e    state_r, state_s;
    logic [31:0]   cnt_r;
    logic [2:0]    det_last_r, fdet_r;
    logic [BW-1:0] det_cnt_r, det_cnt_s;
    logic          back_r, back_set_s, back_clr_s;
    logic          prio_r;
    logic [2:0]    dir_r, dir_s;
    logic          dir_load_s, fault_s;
    logic          push_s, pop_s, clr_s;
    logic [1:0]    push_data_s, rank_s, top_s;
    logic          full_s, empty_s;

    // Length of the current run of identical raw samples, saturating at DEBOUNCE.
    always_comb begin
        det_cnt_s = BW'(1);
        if (detect == det_last_r) begin
            if (det_cnt_r < BW'(DEBOUNCE)) begin
                det_cnt_s = det_cnt_r + BW'(1);
            end else begin
                det_cnt_s = det_cnt_r;
            end
        end else begin
            det_cnt_s = BW'(1);
        end
    end

    // Debounce filter: accept the raw pattern once it has been stable long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            det_last_r <= 3'b000;
            det_cnt_r  <= {BW{1'b0}};
            fdet_r     <= 3'b000;
        end else begin
            det_last_r <= detect;
            det_cnt_r  <= det_cnt_s;
            if (det_cnt_s >= BW'(DEBOUNCE)) begin
                fdet_r <= detect;
            end
        end
    end

    // Next-state and stack control.
    always_comb begin
        state_s     = state_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        push_data_s = RANK_FIRST;
        rank_s      = RANK_FIRST;
        back_set_s  = 1'b0;
        back_clr_s  = 1'b0;
        dir_load_s  = 1'b0;
        dir_s       = dir_r;
        fault_s     = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = ST_ARM;
                ST_ARM:   state_s = (fdet_r == DET_MID) ? ST_COUNT : ST_ARM;
                ST_COUNT: state_s = (cnt_r >= 32'(START_CYCLES - 1)) ? ST_FOLLOW : ST_COUNT;
                ST_FOLLOW: begin
                    if (obstacle) begin
                        state_s = ST_FOLLOW;
                    end else begin
                        case (fdet_r)
                            DET_ALL:  state_s = ST_JUNCTION;
                            DET_NONE: begin
                                state_s    = ST_UTURN;
                                back_set_s = 1'b1;
                            end
                            DET_GOAL: state_s = ST_DONE;
                            default:  state_s = ST_FOLLOW;
                        endcase
                    end
                end
                ST_JUNCTION: begin
                    if (!back_r) begin
                        if (full_s) begin
                            fault_s = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
                    end else begin
                        if (empty_s) begin
                            fault_s = 1'b1;
                        end else if (top_s != RANK_LAST) begin
                            // Try the next option at this junction in place of the exhausted one.
                            pop_s       = 1'b1;
                            push_s      = 1'b1;
                            rank_s      = top_s + 2'd1;
                            push_data_s = top_s + 2'd1;
                            back_clr_s  = 1'b1;
                        end else begin
                            pop_s  = 1'b1;
                            rank_s = RANK_MID;
                        end
                    end
                    if (fault_s) begin
                        state_s = ST_ERROR;
                    end else if (rank_s == RANK_MID) begin
                        state_s = ST_CROSS;
                    end else begin
                        state_s    = ST_TURN;
                        dir_load_s = 1'b1;
                        dir_s      = rank_cmd(prio_r, rank_s);
                    end
                end
                ST_CROSS: state_s = (fdet_r != DET_ALL) ? ST_FOLLOW : ST_CROSS;
                ST_TURN, ST_UTURN: begin
                    if (fdet_r == DET_MID) begin
                        state_s = ST_FOLLOW;
                    end else if (cnt_r >= 32'(TURN_TIMEOUT)) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_DONE:  state_s = ST_DONE;
                ST_ERROR: state_s = ST_ERROR;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    assign clr_s = (state_s == ST_IDLE);

    // State register, per-state cycle counter, backtrack flag and latched choices.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 32'd0;
            back_r  <= 1'b0;
            prio_r  <= 1'b0;
            dir_r   <= CMD_STOP;
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r <= 32'd0;
            end else if (cnt_r != 32'hFFFF_FFFF) begin
                cnt_r <= cnt_r + 32'd1;
            end
            if (clr_s || back_clr_s) begin
                back_r <= 1'b0;
            end else if (back_set_s) begin
                back_r <= 1'b1;
            end
            if (state_r == ST_IDLE) begin
                prio_r <= priority_mode;
            end
            if (dir_load_s) begin
                dir_r <= dir_s;
            end
        end
    end

    decision_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .top       (top_s),
        .count     (depth)
    );

    // Moore command decode; obstacle only gates forward drive while following.
    always_comb begin
        motor_cmd = CMD_STOP;
        case (state_r)
            ST_FOLLOW: motor_cmd = obstacle ? CMD_STOP : CMD_FWD;
            ST_CROSS:  motor_cmd = CMD_FWD;
            ST_TURN:   motor_cmd = dir_r;
            ST_UTURN:  motor_cmd = CMD_SPIN;
            default:   motor_cmd = CMD_STOP;
        endcase
    end

    assign state_code = state_r;
    assign done       = (state_r == ST_DONE);
    assign error      = (state_r == ST_ERROR);

endmodule

// File: tb/tb_maze_navigator.sv
// Scoreboard bench for maze_navigator: expected outputs are queued with each
// stimulus step and compared after the following clock edge.
module tb_maze_navigator;
    import nav_pkg::*;

    localparam int SD = 2;
    localparam int DB = 4;
    localparam int SC = 10;
    localparam int TT = 50;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          rst, enable, priority_mode, obstacle;
    logic [2:0]    detect;
    logic [2:0]    motor_cmd;
    logic [3:0]    state_code;
    logic [DW-1:0] depth;
    logic          done, error;

    typedef struct {
        string tag;
        int    st;
        int    cmd;
        int    dep;
        int    dn;
        int    er;
    } exp_t;

    exp_t sb_q[$];
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    maze_navigator #(
        .STACK_DEPTH  (SD),
        .DEBOUNCE     (DB),
        .START_CYCLES (SC),
        .TURN_TIMEOUT (TT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .priority_mode (priority_mode),
        .detect        (detect),
        .obstacle      (obstacle),
        .motor_cmd     (motor_cmd),
        .state_code    (state_code),
        .depth         (depth),
        .done          (done),
        .error         (error)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, "_state"}, int'(state_code), e.st);
            check_val({e.tag, "_cmd"},   int'(motor_cmd),  e.cmd);
            check_val({e.tag, "_depth"}, int'(depth),      e.dep);
            check_val({e.tag, "_done"},  int'(done),       e.dn);
            check_val({e.tag, "_error"}, int'(error),      e.er);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input int cmd, input int dep,
                              input int dn, input int er);
        exp_t e;
        e.tag = tag; e.st = st; e.cmd = cmd; e.dep = dep; e.dn = dn; e.er = er;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            compare_out();
        end
    endtask

    task automatic step_expect(input string tag, input int st, input int cmd, input int dep,
                               input int dn, input int er);
        expect_out(tag, st, cmd, dep, dn, er);
        tick(1);
    endtask

    task automatic run_to_follow(input string tag);
        enable = 1'b1;
        step_expect({tag, "_arm"}, ST_ARM, CMD_STOP, 0, 0, 0);
        step_expect({tag, "_count"}, ST_COUNT, CMD_STOP, 0, 0, 0);
        tick(SC - 2);
        step_expect({tag, "_count_last"}, ST_COUNT, CMD_STOP, 0, 0, 0);
        step_expect({tag, "_follow"}, ST_FOLLOW, CMD_FWD, 0, 0, 0);
    endtask

    task automatic junction(input string tag, input int dep_before, input int st_after,
                            input int cmd_after, input int dep_after);
        detect = DET_ALL;
        tick(DB - 1);
        step_expect({tag, "_deb"}, ST_FOLLOW, CMD_FWD, dep_before, 0, 0);
        step_expect({tag, "_junc"}, ST_JUNCTION, CMD_STOP, dep_before, 0, 0);
        step_expect({tag, "_exit"}, st_after, cmd_after, dep_after, 0, 0);
    endtask

    task automatic to_follow(input string tag, input int st_from, input int cmd_from, input int dep);
        detect = DET_MID;
        tick(DB - 1);
        step_expect({tag, "_hold"}, st_from, cmd_from, dep, 0, 0);
        step_expect({tag, "_follow"}, ST_FOLLOW, CMD_FWD, dep, 0, 0);
    endtask

    task automatic dead_end(input string tag, input int dep);
        detect = DET_NONE;
        tick(DB - 1);
        step_expect({tag, "_deb"}, ST_FOLLOW, CMD_FWD, dep, 0, 0);
        step_expect({tag, "_uturn"}, ST_UTURN, CMD_SPIN, dep, 0, 0);
    endtask

    task automatic restart();
        enable = 1'b0;
        detect = DET_MID;
        tick(DB);
        expect_out("restart_idle", ST_IDLE, CMD_STOP, 0, 0, 0);
        compare_out();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; priority_mode = 1'b0; obstacle = 1'b0; detect = DET_NONE;
        tick(2);
        step_expect("reset", ST_IDLE, CMD_STOP, 0, 0, 0);
        rst = 1'b0;

        restart();
        run_to_follow("start");

        junction("left", 0, ST_TURN, CMD_LEFT, 1);
        to_follow("left", ST_TURN, CMD_LEFT, 1);

        detect = DET_NONE;
        tick(1);
        detect = DET_MID;
        tick(DB + 1);
        step_expect("glitch", ST_FOLLOW, CMD_FWD, 1, 0, 0);

        obstacle = 1'b1;
        #1;
        expect_out("obs_stop", ST_FOLLOW, CMD_STOP, 1, 0, 0);
        compare_out();
        detect = DET_NONE;
        tick(DB + 1);
        step_expect("obs_hold", ST_FOLLOW, CMD_STOP, 1, 0, 0);
        obstacle = 1'b0;
        #1;
        expect_out("obs_release", ST_FOLLOW, CMD_FWD, 1, 0, 0);
        compare_out();
        step_expect("dead_uturn", ST_UTURN, CMD_SPIN, 1, 0, 0);
        to_follow("dead", ST_UTURN, CMD_SPIN, 1);

        junction("back1", 1, ST_CROSS, CMD_FWD, 1);
        to_follow("back1", ST_CROSS, CMD_FWD, 1);
        dead_end("dead2", 1);
        to_follow("dead2", ST_UTURN, CMD_SPIN, 1);
        junction("back2", 1, ST_TURN, CMD_RIGHT, 1);
        to_follow("back2", ST_TURN, CMD_RIGHT, 1);
        dead_end("dead3", 1);
        to_follow("dead3", ST_UTURN, CMD_SPIN, 1);
        junction("back3", 1, ST_CROSS, CMD_FWD, 0);
        to_follow("back3", ST_CROSS, CMD_FWD, 0);
        detect = DET_ALL;
        tick(DB);
        step_expect("exhaust_junc", ST_JUNCTION, CMD_STOP, 0, 0, 0);
        step_expect("exhaust", ST_ERROR, CMD_STOP, 0, 0, 1);
        tick(3);
        step_expect("exhaust_hold", ST_ERROR, CMD_STOP, 0, 0, 1);
        enable = 1'b0;
        step_expect("exhaust_clear", ST_IDLE, CMD_STOP, 0, 0, 0);

        restart();
        run_to_follow("full");
        junction("full1", 0, ST_TURN, CMD_LEFT, 1);
        to_follow("full1", ST_TURN, CMD_LEFT, 1);
        junction("full2", 1, ST_TURN, CMD_LEFT, 2);
        to_follow("full2", ST_TURN, CMD_LEFT, 2);
        detect = DET_ALL;
        tick(DB);
        step_expect("full3_junc", ST_JUNCTION, CMD_STOP, 2, 0, 0);
        step_expect("full3", ST_ERROR, CMD_STOP, 2, 0, 1);
        enable = 1'b0;
        step_expect("full_clear", ST_IDLE, CMD_STOP, 0, 0, 0);

        priority_mode = 1'b1;
        restart();
        run_to_follow("rh");
        junction("rh", 0, ST_TURN, CMD_RIGHT, 1);
        enable = 1'b0;
        step_expect("abort", ST_IDLE, CMD_STOP, 0, 0, 0);

        priority_mode = 1'b0;
        restart();
        run_to_follow("to");
        junction("to", 0, ST_TURN, CMD_LEFT, 1);
        tick(TT - 1);
        step_expect("to_hold", ST_TURN, CMD_LEFT, 1, 0, 0);
        step_expect("timeout", ST_ERROR, CMD_STOP, 1, 0, 1);

        restart();
        run_to_follow("goal");
        detect = DET_GOAL;
        tick(DB - 1);
        step_expect("goal_deb", ST_FOLLOW, CMD_FWD, 0, 0, 0);
        step_expect("goal", ST_DONE, CMD_STOP, 0, 1, 0);
        tick(3);
        step_expect("goal_hold", ST_DONE, CMD_STOP, 0, 1, 0);
        enable = 1'b0;
        step_expect("goal_clear", ST_IDLE, CMD_STOP, 0, 0, 0);

        restart();
        run_to_follow("rst");
        junction("rst", 0, ST_TURN, CMD_LEFT, 1);
        rst = 1'b1;
        step_expect("rst_mid", ST_IDLE, CMD_STOP, 0, 0, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 checks_cnt, errors_cnt);
        $fatal(1, "watchdog");
    end

endmodule
